// File: rtl/fir_pe_seq.sv
// Sequencer between a valid/ready job stream and a nibble-serial FIR processing element.
// Each job is sent as two PE input beats, and the result comes back as two PE output beats.
module fir_pe_seq #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [7:0] cfg_coef,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_x,
    input  logic [7:0] s_y,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_x,
    output logic [7:0] m_y,
    output logic [7:0] pe_Cin,
    output logic [3:0] pe_Xin,
    output logic [3:0] pe_Yin,
    output logic       pe_Rdy,
    input  logic [3:0] pe_Xout,
    input  logic [3:0] pe_Yout,
    input  logic       pe_Vld,
    output logic       err,
    input  logic       err_clr
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_LO,
        SEND_HI,
        WAIT_LO,
        WAIT_HI,
        OUT
    } state_t;

    localparam logic [4:0] TIMEOUT_CNT = TIMEOUT[4:0];

    state_t     state, state_nxt;
    logic [7:0] x_q, y_q, coef_q, mx_q, my_q;
    logic [4:0] cnt_q, cnt_nxt;
    logic       err_set;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        err_set   = 1'b0;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        pe_Rdy    = 1'b0;
        pe_Xin    = 4'h0;
        pe_Yin    = 4'h0;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                if (s_valid) state_nxt = SEND_LO;
            end
            SEND_LO: begin
                pe_Rdy    = 1'b1;
                pe_Xin    = x_q[3:0];
                pe_Yin    = y_q[3:0];
                state_nxt = SEND_HI;
            end
            SEND_HI: begin
                pe_Rdy    = 1'b1;
                pe_Xin    = x_q[7:4];
                pe_Yin    = y_q[7:4];
                cnt_nxt   = 5'd0;
                state_nxt = WAIT_LO;
            end
            WAIT_LO: begin
                if (pe_Vld) begin
                    state_nxt = WAIT_HI;
                end else begin
                    // Timeout fires at the end of the TIMEOUT-th cycle without a beat.
                    cnt_nxt = cnt_q + 5'd1;
                    if (cnt_q + 5'd1 == TIMEOUT_CNT) begin
                        err_set   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_HI: begin
                if (pe_Vld) begin
                    state_nxt = OUT;
                end else begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt_q  <= 5'd0;
            x_q    <= 8'h00;
            y_q    <= 8'h00;
            coef_q <= 8'h00;
            mx_q   <= 8'h00;
            my_q   <= 8'h00;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            if (state == IDLE && s_valid) begin
                x_q <= s_x;
                y_q <= s_y;
            end
            // Coefficient only changes between jobs so Cin is stable across a whole job.
            if (state == IDLE && cfg_we) coef_q <= cfg_coef;
            if (state == WAIT_LO && pe_Vld) begin
                mx_q[3:0] <= pe_Xout;
                my_q[3:0] <= pe_Yout;
            end
            if (state == WAIT_HI && pe_Vld) begin
                mx_q[7:4] <= pe_Xout;
                my_q[7:4] <= pe_Yout;
            end
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

    assign m_x    = mx_q;
    assign m_y    = my_q;
    assign pe_Cin = coef_q;

endmodule

// File: tb/tb_fir_pe_seq.sv
// Directed self-checking bench for fir_pe_seq; the PE side is driven by hand-picked beats.
module tb_fir_pe_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [7:0] cfg_coef;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_x, s_y;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_x, m_y;
    logic [7:0] pe_Cin;
    logic [3:0] pe_Xin, pe_Yin;
    logic       pe_Rdy;
    logic [3:0] pe_Xout, pe_Yout;
    logic       pe_Vld;
    logic       err;
    logic       err_clr;

    int tests_run    = 0;
    int tests_failed = 0;

    fir_pe_seq #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_coef(cfg_coef),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y),
        .pe_Cin(pe_Cin), .pe_Xin(pe_Xin), .pe_Yin(pe_Yin), .pe_Rdy(pe_Rdy),
        .pe_Xout(pe_Xout), .pe_Yout(pe_Yout), .pe_Vld(pe_Vld),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] x, input logic [7:0] y);
        s_valid = 1'b1;
        s_x     = x;
        s_y     = y;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 0; cfg_coef = 0; s_valid = 0; s_x = 0; s_y = 0;
        m_ready = 1'b1; pe_Xout = 0; pe_Yout = 0; pe_Vld = 0; err_clr = 0;
        tick(); tick();
        rst = 1'b0;
        tests_run++;
        if ({s_ready, m_valid, pe_Rdy, err} !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got s_ready,m_valid,pe_Rdy,err=%b want 1000",
                     {s_ready, m_valid, pe_Rdy, err});
        end
        tests_run++;
        if ({pe_Cin, m_x, m_y, pe_Xin, pe_Yin} !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got Cin=%h m_x=%h m_y=%h Xin=%h Yin=%h want all 0",
                     pe_Cin, m_x, m_y, pe_Xin, pe_Yin);
        end
    endtask

    task automatic test_config();
        cfg_we = 1'b1; cfg_coef = 8'h21;
        tick();
        cfg_we = 1'b0;
        tests_run++;
        if (pe_Cin !== 8'h21) begin
            tests_failed++;
            $display("[TB] FAIL cfg_idle: got Cin=%h want 21", pe_Cin);
        end
    endtask

    task automatic test_basic_job();
        start_job(8'hA5, 8'h3C);
        tests_run++;
        if ({pe_Rdy, pe_Xin, pe_Yin} !== 9'h1_5C) begin
            tests_failed++;
            $display("[TB] FAIL basic_beat_lo: got Rdy=%b Xin=%h Yin=%h want 1 5 C", pe_Rdy, pe_Xin, pe_Yin);
        end
        tick();
        tests_run++;
        if ({pe_Rdy, pe_Xin, pe_Yin} !== 9'h1_A3) begin
            tests_failed++;
            $display("[TB] FAIL basic_beat_hi: got Rdy=%b Xin=%h Yin=%h want 1 A 3", pe_Rdy, pe_Xin, pe_Yin);
        end
        tick();
        tests_run++;
        if ({pe_Rdy, pe_Xin, pe_Yin, pe_Cin} !== 17'h0_0021) begin
            tests_failed++;
            $display("[TB] FAIL basic_wait: got Rdy=%b Xin=%h Yin=%h Cin=%h want 0 0 0 21",
                     pe_Rdy, pe_Xin, pe_Yin, pe_Cin);
        end
        pe_Vld = 1'b1; pe_Xout = 4'h5; pe_Yout = 4'h7;
        tick();
        pe_Xout = 4'hA; pe_Yout = 4'h1;
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_early_valid: got m_valid=%b want 0", m_valid);
        end
        tick();
        pe_Vld = 1'b0; pe_Xout = 0; pe_Yout = 0;
        tests_run++;
        if ({m_valid, s_ready, m_x, m_y} !== 18'b10_1010_0101_0001_0111) begin
            tests_failed++;
            $display("[TB] FAIL basic_result: got m_valid=%b s_ready=%b m_x=%h m_y=%h want 1 0 A5 17",
                     m_valid, s_ready, m_x, m_y);
        end
        tick();
        tests_run++;
        if ({m_valid, s_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL basic_return_idle: got m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] xs [2] = '{8'h12, 8'hFE};
        logic [7:0] ys [2] = '{8'h34, 8'h01};
        logic [7:0] xo [2] = '{8'h9A, 8'h33};
        logic [7:0] yo [2] = '{8'hBC, 8'h44};
        s_valid = 1'b1;
        for (int j = 0; j < 2; j++) begin
            s_x = xs[j]; s_y = ys[j];
            tests_run++;
            if (s_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL b2b_ready job%0d: got s_ready=%b want 1", j, s_ready);
            end
            tick();
            tests_run++;
            if ({pe_Rdy, pe_Xin, pe_Yin} !== {1'b1, xs[j][3:0], ys[j][3:0]}) begin
                tests_failed++;
                $display("[TB] FAIL b2b_beat_lo job%0d: got Rdy=%b Xin=%h Yin=%h want 1 %h %h",
                         j, pe_Rdy, pe_Xin, pe_Yin, xs[j][3:0], ys[j][3:0]);
            end
            tick();
            tests_run++;
            if ({pe_Rdy, pe_Xin, pe_Yin} !== {1'b1, xs[j][7:4], ys[j][7:4]}) begin
                tests_failed++;
                $display("[TB] FAIL b2b_beat_hi job%0d: got Rdy=%b Xin=%h Yin=%h want 1 %h %h",
                         j, pe_Rdy, pe_Xin, pe_Yin, xs[j][7:4], ys[j][7:4]);
            end
            tick();
            pe_Vld = 1'b1; pe_Xout = xo[j][3:0]; pe_Yout = yo[j][3:0];
            tick();
            pe_Xout = xo[j][7:4]; pe_Yout = yo[j][7:4];
            tick();
            pe_Vld = 1'b0;
            tests_run++;
            if ({m_valid, m_x, m_y} !== {1'b1, xo[j], yo[j]}) begin
                tests_failed++;
                $display("[TB] FAIL b2b_result job%0d: got m_valid=%b m_x=%h m_y=%h want 1 %h %h",
                         j, m_valid, m_x, m_y, xo[j], yo[j]);
            end
            tick();
        end
        s_valid = 1'b0;
        tests_run++;
        if ({s_ready, m_valid} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL b2b_end: got s_ready=%b m_valid=%b want 1 0", s_ready, m_valid);
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        m_ready = 1'b0;
        start_job(8'h5A, 8'hC3);
        tick(); tick();
        pe_Vld = 1'b1; pe_Xout = 4'hE; pe_Yout = 4'h6;
        tick();
        pe_Xout = 4'h7; pe_Yout = 4'h2;
        tick();
        pe_Vld = 1'b0; pe_Xout = 4'hF; pe_Yout = 4'hF;
        for (int i = 0; i < 5; i++) begin
            if ({m_valid, s_ready, m_x, m_y} !== 18'b10_0111_1110_0010_0110) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_hold: %0d of 5 cycles wrong, last m_valid=%b s_ready=%b m_x=%h m_y=%h want 1 0 7E 26",
                     bad, m_valid, s_ready, m_x, m_y);
        end
        m_ready = 1'b1;
        tests_run++;
        if ({m_valid, m_x, m_y} !== 17'b1_0111_1110_0010_0110) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_release: got m_valid=%b m_x=%h m_y=%h want 1 7E 26", m_valid, m_x, m_y);
        end
        tick();
        tests_run++;
        if ({m_valid, s_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL backpressure_done: got m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
        end
        pe_Xout = 0; pe_Yout = 0;
    endtask

    task automatic test_config_gating();
        start_job(8'h11, 8'h22);
        tick(); tick();
        cfg_we = 1'b1; cfg_coef = 8'h55;
        tick();
        cfg_we = 1'b0;
        tests_run++;
        if (pe_Cin !== 8'h21) begin
            tests_failed++;
            $display("[TB] FAIL cfg_gated_wait: got Cin=%h want 21", pe_Cin);
        end
        pe_Vld = 1'b1; pe_Xout = 4'h1; pe_Yout = 4'h2;
        tick(); tick();
        pe_Vld = 1'b0;
        tick();
        tests_run++;
        if ({s_ready, pe_Cin} !== 9'h1_21) begin
            tests_failed++;
            $display("[TB] FAIL cfg_job_end: got s_ready=%b Cin=%h want 1 21", s_ready, pe_Cin);
        end
        cfg_we = 1'b1; cfg_coef = 8'h55;
        tick();
        cfg_we = 1'b0;
        tests_run++;
        if (pe_Cin !== 8'h55) begin
            tests_failed++;
            $display("[TB] FAIL cfg_idle_write: got Cin=%h want 55", pe_Cin);
        end
    endtask

    task automatic test_timeout();
        int seen_valid = 0;
        start_job(8'h77, 8'h88);
        tick(); tick();
        for (int i = 0; i < 15; i++) begin
            if (m_valid) seen_valid++;
            tick();
        end
        tests_run++;
        if ({err, s_ready, m_valid} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL timeout_early: after 15 wait cycles got err=%b s_ready=%b m_valid=%b want 0 0 0",
                     err, s_ready, m_valid);
        end
        tick();
        tests_run++;
        if ({err, s_ready, m_valid} !== 3'b110 || seen_valid != 0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_fire: got err=%b s_ready=%b m_valid=%b valid_cycles=%0d want 1 1 0 0",
                     err, s_ready, m_valid, seen_valid);
        end
        tick();
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL timeout_sticky: got err=%b want 1", err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL timeout_clear: got err=%b want 0", err);
        end
    endtask

    task automatic test_broken_vld();
        start_job(8'h3D, 8'h4E);
        tick(); tick();
        pe_Vld = 1'b1; pe_Xout = 4'h1; pe_Yout = 4'h2;
        tick();
        pe_Vld = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++;
        if ({err, s_ready, m_valid} !== 3'b110) begin
            tests_failed++;
            $display("[TB] FAIL broken_vld: got err=%b s_ready=%b m_valid=%b want 1 1 0 (error beats clear)",
                     err, s_ready, m_valid);
        end
        tick();
        tests_run++;
        if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL broken_no_result: got m_valid=%b want 0", m_valid);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        int seen_valid = 0;
        start_job(8'h99, 8'h66);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({pe_Rdy, s_ready, m_valid, pe_Xin, pe_Yin, pe_Cin} !== 19'b010_0000_0000_0000_0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: got Rdy=%b s_ready=%b m_valid=%b Xin=%h Yin=%h Cin=%h want 0 1 0 0 0 00",
                     pe_Rdy, s_ready, m_valid, pe_Xin, pe_Yin, pe_Cin);
        end
        pe_Vld = 1'b1; pe_Xout = 4'hC; pe_Yout = 4'hD;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (m_valid || !s_ready || pe_Rdy) seen_valid++;
        end
        pe_Vld = 1'b0;
        tests_run++;
        if (seen_valid != 0 || m_x !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_dropped: bad cycles=%0d m_x=%h want 0 and 00", seen_valid, m_x);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_config();
        test_basic_job();
        test_back_to_back();
        test_backpressure();
        test_config_gating();
        test_timeout();
        test_broken_vld();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fir_pe_seq.md
FIR_PE_SEQ -- requirements
Module: fir_pe_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles to wait for pe_Vld after the second Rdy beat (range 2..31).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port cfg_we, input, 1, the coefficient write strobe.
REQ-005 SHALL have port cfg_coef, input, 8, the coefficient value.
REQ-006 SHALL have port s_valid, input, 1, meaning a source job is offered.
REQ-007 SHALL have port s_ready, output, 1, meaning the sequencer accepts a job.
REQ-008 SHALL have port s_x, input, 8, the input sample.
REQ-009 SHALL have port s_y, input, 8, the incoming partial sum.
REQ-010 SHALL have port m_valid, output, 1, meaning a result is available.
REQ-011 SHALL have port m_ready, input, 1, meaning the sink accepts the result.
REQ-012 SHALL have port m_x, output, 8, the passed-through sample from the PE.
REQ-013 SHALL have port m_y, output, 8, the updated partial sum from the PE.
REQ-014 SHALL have port pe_Cin, output, 8, the coefficient to the PE.
REQ-015 SHALL have ports pe_Xin and pe_Yin, output, 4 each, the nibble-serial sample and partial sum to the PE.
REQ-016 SHALL have port pe_Rdy, output, 1, marking the PE input beats.
REQ-017 SHALL have ports pe_Xout and pe_Yout, input, 4 each, the nibble-serial PE results.
REQ-018 SHALL have port pe_Vld, input, 1, marking the PE result beats.
REQ-019 SHALL have port err, output, 1, a sticky timeout flag.
REQ-020 SHALL have port err_clr, input, 1, which clears err.

Function
REQ-021 SHALL implement FSM states IDLE, SEND_LO, SEND_HI, WAIT_LO, WAIT_HI, OUT.
REQ-022 SHALL drive s_ready=1 only in IDLE; a handshake (s_valid&s_ready) SHALL latch s_x and s_y and move to SEND_LO.
REQ-023 SHALL, in SEND_LO, drive pe_Rdy=1, pe_Xin=x[3:0], pe_Yin=y[3:0], then go to SEND_HI.
REQ-024 SHALL, in SEND_HI, drive pe_Rdy=1, pe_Xin=x[7:4], pe_Yin=y[7:4], then go to WAIT_LO and clear the timeout counter.
REQ-025 SHALL drive pe_Rdy=0 and pe_Xin/pe_Yin=0 in all other states; pe_Rdy SHALL therefore be high for exactly 2 consecutive cycles per job.
REQ-026 SHALL, in WAIT_LO, capture pe_Xout/pe_Yout into m_x[3:0]/m_y[3:0] on the cycle pe_Vld=1 and go to WAIT_HI.
REQ-027 SHALL, in WAIT_LO, increment the 5-bit timeout counter on each cycle with pe_Vld=0.
REQ-028 SHALL, in WAIT_HI, require pe_Vld=1 on the very next cycle and capture m_x[7:4]/m_y[7:4], then go to OUT.
REQ-029 SHALL treat pe_Vld=0 in WAIT_HI as a protocol error: set err, discard the job, and go to IDLE.
REQ-030 SHALL, when the counter reaches TIMEOUT in WAIT_LO without pe_Vld, set err, discard the job, and go to IDLE with m_valid never asserted.
REQ-031 SHALL drive m_valid=1 only in OUT, holding m_x/m_y stable until m_ready=1, then go to IDLE.
REQ-032 SHALL support back-to-back operation: the minimum job period is 6 cycles (IDLE, SEND_LO, SEND_HI, WAIT_LO, WAIT_HI, OUT) when pe_Vld arrives on the first WAIT_LO cycle and m_ready=1.
REQ-033 SHALL have a coefficient register driving pe_Cin continuously; cfg_we SHALL update it only in IDLE and SHALL be ignored in all other states, so Cin is stable for a whole job.
REQ-034 SHALL make err sticky until err_clr=1; if a new error and err_clr coincide, err SHALL be set (the error wins).
REQ-035 SHALL ignore pe_Vld in IDLE, SEND_LO, SEND_HI and OUT.

Reset
REQ-036 SHALL, on rst=1 at a clock edge and from any state, go to IDLE with s_ready=1 on the following cycle, and drive m_valid=0, pe_Rdy=0, pe_Xin=0, pe_Yin=0, pe_Cin=0, m_x=0, m_y=0, err=0 and the counter at 0.
REQ-037 SHALL, on reset mid-job, drop the in-flight job without any output beat.
REQ-038 SHALL give rst priority over cfg_we, s_valid and err_clr.

Verification
REQ-039 Basic job: coef=0x21; job x=0xA5, y=0x3C -> pe_Rdy beats (Xin,Yin)=(5,C),(A,3); PE returns (Xout,Yout)=(5,7),(A,1) -> m_x=0xA5, m_y=0x17, m_valid high 1 cycle later.
REQ-040 Backpressure: m_ready=0 for 5 cycles in OUT -> m_valid, m_x and m_y held; s_ready=0 throughout.
REQ-041 Timeout: no pe_Vld after SEND_HI -> after TIMEOUT=16 wait cycles, err=1, IDLE, no m_valid; err_clr -> err=0.
REQ-042 Broken Vld pair: pe_Vld high for 1 cycle only -> err=1, return to IDLE, no m_valid.
REQ-043 Config gating: cfg_we with coef=0x55 during WAIT_LO -> pe_Cin unchanged; the same write in IDLE -> pe_Cin=0x55 next cycle.
REQ-044 Reset in SEND_HI -> next cycle pe_Rdy=0, s_ready=1, and no result beat for the dropped job.
